// File: rtl/ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1.sv
// ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1: DQS-reset request initiator with ack wait, low gap, timeout retry and sticky error
module ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1 #(
  parameter int TIMEOUT_CLK = 64,
  parameter int MIN_LOW_CLK = 4,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ddrphy_in_rst,
  input  logic       dqs_rst_trig,
  input  logic       err_clr,
  input  logic       ddrphy_rst_ack,
  output logic       ddrphy_rst_req,
  output logic       rst_busy,
  output logic       rst_done,
  output logic       rst_err,
  output logic [1:0] retry_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, GAP, ERR} state_t;
  // The IDLE cycle that relaunches a pending request is itself one low cycle,
  // so GAP only needs to cover the remaining MIN_LOW_CLK-1 cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CLK - 1);
  localparam logic [7:0] GAP_LAST = 8'(MIN_LOW_CLK - 2);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic       cont_q, cont_d;
  logic       req_q, req_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] retry_q, retry_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] gap_q, gap_d;
  // Next state: cont marks a re-attempt (timeout retry or abort) that must keep retry_cnt.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | (dqs_rst_trig & (state_q != ERR));
    cont_d    = cont_q;
    done_d    = 1'b0;
    err_d     = err_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: if ((dqs_rst_trig | pending_q) && !ddrphy_in_rst) begin
        state_d = REQ;
        tmo_d   = 8'd0;
        retry_d = cont_q ? retry_q : 2'd0;
      end
      REQ: begin
        gap_d = 8'd0;
        if (ddrphy_in_rst) begin
          state_d   = GAP;
          pending_d = 1'b1;
          cont_d    = 1'b1;
        end else if (ddrphy_rst_ack) begin
          state_d = GAP;
          done_d  = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d   = GAP;
            retry_d   = retry_q + 2'd1;
            pending_d = 1'b1;
            cont_d    = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end else tmo_d = tmo_q + 8'd1;
      end
      GAP: if (gap_q == GAP_LAST) state_d = IDLE; else gap_d = gap_q + 8'd1;
      default: if (err_clr) begin
        state_d   = IDLE;
        err_d     = 1'b0;
        retry_d   = 2'd0;
        pending_d = 1'b0;
        cont_d    = 1'b0;
      end
    endcase
    if (state_d == REQ && state_q != REQ) begin
      pending_d = 1'b0;
      cont_d    = 1'b0;
    end
    req_d = (state_d == REQ);
  end
  // State and registered outputs; reset drops the request immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cont_q    <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retry_q   <= 2'd0;
      tmo_q     <= 8'd0;
      gap_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cont_q    <= cont_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
    end
  end
  assign ddrphy_rst_req = req_q;
  assign rst_busy       = (state_q == REQ) || (state_q == GAP);
  assign rst_done       = done_q;
  assign rst_err        = err_q;
  assign retry_cnt      = retry_q;
endmodule

// File: tb/tb_ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1.sv
// tb_ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1: directed scoreboard bench for the DQS-reset request initiator
module tb_ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1;
  logic clk = 0, rstn = 0, in_rst = 0, trig = 0, err_clr = 0, ack_man = 0, ack_auto = 0;
  logic ack, req, busy, done, err;
  logic [1:0] retry;
  int checks = 0, errors = 0, ack_at = 0, hi_len = 0, lo_len = 0, n_done = 0;
  bit seen_fall = 0;
  int obs_hi[$], obs_lo[$], exp_hi[$], exp_lo[$];
  assign ack = ack_auto | ack_man;
  always #5 clk = ~clk;
  ipsl_hmic_h_ddrphy_rst_req_ctrl_v1_1 dut (
    .clk(clk), .rstn(rstn), .ddrphy_in_rst(in_rst), .dqs_rst_trig(trig),
    .err_clr(err_clr), .ddrphy_rst_ack(ack), .ddrphy_rst_req(req),
    .rst_busy(busy), .rst_done(done), .rst_err(err), .retry_cnt(retry)
  );
  // Monitor: measures req high/low run lengths and done pulses; responder acks in req cycle ack_at.
  always @(negedge clk) begin
    ack_auto = 0;
    if (req) begin
      if (hi_len == 0 && seen_fall) obs_lo.push_back(lo_len);
      hi_len++;
      lo_len = 0;
      ack_auto = (ack_at != 0 && hi_len == ack_at);
    end else begin
      if (hi_len != 0) begin
        obs_hi.push_back(hi_len);
        seen_fall = 1;
      end
      hi_len = 0;
      lo_len++;
    end
    if (done) n_done++;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pulse_trig;
    trig = 1;
    tick();
    trig = 0;
  endtask
  task automatic clr_mon;
    obs_hi.delete(); obs_lo.delete(); exp_hi.delete(); exp_lo.delete();
    seen_fall = 0; n_done = 0; lo_len = 0;
  endtask
  task automatic drain(input string tag, input int exp_done);
    chk({tag, "_npulse"}, obs_hi.size(), exp_hi.size());
    chk({tag, "_ngap"}, obs_lo.size(), exp_lo.size());
    while (obs_hi.size() > 0 && exp_hi.size() > 0) chk({tag, "_hi"}, obs_hi.pop_front(), exp_hi.pop_front());
    while (obs_lo.size() > 0 && exp_lo.size() > 0) chk({tag, "_lo"}, obs_lo.pop_front(), exp_lo.pop_front());
    chk({tag, "_done"}, n_done, exp_done);
    clr_mon();
  endtask
  task automatic wait_hi(input int n, input int bound);
    int k = 0;
    while (obs_hi.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk("wait_pulse", 32'(obs_hi.size() >= n), 1);
  endtask
  initial begin
    tick(2);
    chk("rst_req", req, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_retry", retry, 0);
    rstn = 1;
    tick(2);
    clr_mon();
    // single request, ack in req cycle 9
    ack_at = 9;
    exp_hi.push_back(9);
    pulse_trig();
    chk("p1_req_rise", req, 1);
    chk("p1_busy", busy, 1);
    tick(30);
    chk("p1_retry", retry, 0); chk("p1_err", err, 0); chk("p1_idle", busy, 0);
    drain("p1", 1);
    // three triggers deferred by in_rst coalesce into one request
    in_rst = 1;
    pulse_trig(); tick(); pulse_trig(); tick(); pulse_trig();
    tick(3);
    chk("p2_deferred_req", req, 0);
    chk("p2_deferred_busy", busy, 0);
    in_rst = 0;
    exp_hi.push_back(9);
    tick(30);
    drain("p2", 1);
    // trigger during REQ queues a second request after a 4-cycle gap
    exp_hi.push_back(9); exp_hi.push_back(9); exp_lo.push_back(4);
    pulse_trig();
    tick(2);
    pulse_trig();
    tick(40);
    drain("p3", 2);
    // no ack: two retries then sticky error
    ack_at = 0;
    repeat (3) exp_hi.push_back(64);
    exp_lo.push_back(4); exp_lo.push_back(4);
    pulse_trig();
    wait_hi(1, 100);
    chk("p4_retry1", retry, 1);
    wait_hi(2, 100);
    chk("p4_retry2", retry, 2);
    wait_hi(3, 100);
    tick(2);
    chk("p4_err", err, 1); chk("p4_err_retry", retry, 2);
    chk("p4_err_req", req, 0); chk("p4_err_busy", busy, 0);
    pulse_trig();
    tick(10);
    chk("p4_trig_in_err_req", req, 0);
    chk("p4_err_sticky", err, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("p4_clr_err", err, 0); chk("p4_clr_retry", retry, 0);
    tick(10);
    chk("p4_no_relaunch", req, 0);
    drain("p4", 0);
    // ack coincident with the last timeout cycle wins
    ack_at = 64;
    exp_hi.push_back(64);
    pulse_trig();
    tick(80);
    chk("p5_retry", retry, 0); chk("p5_err", err, 0);
    drain("p5", 1);
    // ack outside REQ is ignored
    ack_at = 0;
    ack_man = 1;
    tick();
    ack_man = 0;
    tick(3);
    chk("p6_busy", busy, 0); chk("p6_req", req, 0);
    drain("p6", 0);
    // in_rst at REQ cycle 5 for 10 cycles aborts and relaunches
    ack_at = 9;
    exp_hi.push_back(5); exp_hi.push_back(9); exp_lo.push_back(10);
    pulse_trig();
    tick(4);
    in_rst = 1;
    tick();
    chk("p7_abort_req", req, 0);
    chk("p7_abort_done", done, 0);
    tick(9);
    in_rst = 0;
    tick(30);
    chk("p7_retry", retry, 0);
    drain("p7", 1);
    // asynchronous reset mid-request
    ack_at = 0;
    pulse_trig();
    tick(3);
    #2 rstn = 0;
    #1;
    chk("p8_req", req, 0); chk("p8_busy", busy, 0); chk("p8_done", done, 0);
    chk("p8_err", err, 0); chk("p8_retry", retry, 0);
    tick(2);
    rstn = 1;
    tick(2);
    clr_mon();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
